// File: rtl/flag_cond_unit.sv
// ============================================================================
// Module   : flag_cond_unit
// Brief    : Masked-update status flag register with a registered, handshaked
//            branch-condition evaluator. Optional save/restore shadow register
//            is built when FLAG_COND_SHADOW_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module flag_cond_unit #(
  parameter int                   NUM_FLAGS   = 5,
  parameter int                   SEL_W       = 3,
  parameter logic [NUM_FLAGS-1:0] RESET_FLAGS = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_flag_we,
  input  logic [NUM_FLAGS-1:0] i_flag_mask,
  input  logic [NUM_FLAGS-1:0] i_flag_in,
  input  logic                 i_save,
  input  logic                 i_restore,
  input  logic                 i_cond_valid,
  output logic                 o_cond_ready,
  input  logic [SEL_W-1:0]     i_sel_f,
  input  logic                 i_inv_f,
  output logic                 o_s_valid,
  input  logic                 i_s_ready,
  output logic                 o_s_flag,
  output logic                 o_sel_err,
  output logic [NUM_FLAGS-1:0] o_r_flag
);

  localparam int               c_EXT_W    = 1 << SEL_W;
  localparam logic [SEL_W-1:0] c_TRUE_SEL = SEL_W'(NUM_FLAGS);

  logic [NUM_FLAGS-1:0] r_flag;
  logic                 r_s_valid;
  logic                 r_s_flag;
  logic                 r_sel_err;

  logic [NUM_FLAGS-1:0] w_mask;
  logic [NUM_FLAGS-1:0] w_upd;
  logic [NUM_FLAGS-1:0] w_nf;
  logic [c_EXT_W-1:0]   w_ext;
  logic                 w_accept;
  logic                 w_err;
  logic                 w_result;

  assign w_mask = i_flag_we ? i_flag_mask : '0;
  assign w_upd  = (r_flag & ~w_mask) | (i_flag_in & w_mask);

`ifdef FLAG_COND_SHADOW_EN
  logic [NUM_FLAGS-1:0] r_shadow;

  // Restore overrides any write; save captures the pre-update flags (swap when both).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_shadow <= RESET_FLAGS;
    end else if (i_save) begin
      r_shadow <= r_flag;
    end
  end

  assign w_nf = i_restore ? r_shadow : w_upd;
`else
  logic w_unused_shadow;
  assign w_unused_shadow = i_save ^ i_restore;
  assign w_nf            = w_upd;
`endif

  // Extended select space: the code just past the last flag reads as constant true.
  always_comb begin
    w_ext                  = '0;
    w_ext[NUM_FLAGS-1:0]   = w_nf;
    w_ext[NUM_FLAGS]       = 1'b1;
  end

  assign w_err        = (i_sel_f > c_TRUE_SEL);
  assign w_result     = w_err ? 1'b0 : (w_ext[i_sel_f] ^ i_inv_f);
  assign o_cond_ready = ~r_s_valid | i_s_ready;
  assign w_accept     = i_cond_valid & o_cond_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_flag <= RESET_FLAGS;
    end else begin
      r_flag <= w_nf;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s_valid <= 1'b0;
      r_s_flag  <= 1'b0;
      r_sel_err <= 1'b0;
    end else if (w_accept) begin
      r_s_valid <= 1'b1;
      r_s_flag  <= w_result;
      r_sel_err <= w_err;
    end else if (i_s_ready) begin
      r_s_valid <= 1'b0;
    end
  end

  assign o_s_valid = r_s_valid;
  assign o_s_flag  = r_s_flag;
  assign o_sel_err = r_sel_err;
  assign o_r_flag  = r_flag;

endmodule

`default_nettype wire

// File: tb/tb_flag_cond_unit.sv
// ============================================================================
// Module   : tb_flag_cond_unit
// Brief    : Directed, table-driven self-checking bench for flag_cond_unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_flag_cond_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       flag_we;
  logic [4:0] flag_mask;
  logic [4:0] flag_in;
  logic       save;
  logic       restore;
  logic       cond_valid;
  logic       cond_ready;
  logic [2:0] sel_f;
  logic       inv_f;
  logic       s_valid;
  logic       s_ready;
  logic       s_flag;
  logic       sel_err;
  logic [4:0] r_flag;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  flag_cond_unit #(
    .NUM_FLAGS   (5),
    .SEL_W       (3),
    .RESET_FLAGS (5'b00101)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_flag_we    (flag_we),
    .i_flag_mask  (flag_mask),
    .i_flag_in    (flag_in),
    .i_save       (save),
    .i_restore    (restore),
    .i_cond_valid (cond_valid),
    .o_cond_ready (cond_ready),
    .i_sel_f      (sel_f),
    .i_inv_f      (inv_f),
    .o_s_valid    (s_valid),
    .i_s_ready    (s_ready),
    .o_s_flag     (s_flag),
    .o_sel_err    (sel_err),
    .o_r_flag     (r_flag)
  );

  typedef struct {
    logic       we;
    logic [4:0] mask;
    logic [4:0] fin;
    logic [2:0] sel;
    logic       inv;
    logic       exp_flag;
    logic       exp_err;
    logic [4:0] exp_rflag;
  } vec_t;

  vec_t vecs [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flag_we = 1'b0; flag_mask = '0; flag_in = '0;
    save = 1'b0; restore = 1'b0;
    cond_valid = 1'b0; sel_f = '0; inv_f = 1'b0;
  endtask

  task automatic write_flags(input logic [4:0] val);
    flag_we = 1'b1; flag_mask = 5'b11111; flag_in = val;
    tick();
    flag_we = 1'b0; flag_mask = '0; flag_in = '0;
  endtask

  logic [7:0] tp_exp_flag;
  logic [7:0] tp_exp_err;

  initial begin
    // {we, mask, in, sel, inv, exp_flag, exp_err, exp_rflag}
    vecs[0]  = '{1'b1, 5'b11111, 5'b10010, 3'd1, 1'b0, 1'b1, 1'b0, 5'b10010};
    vecs[1]  = '{1'b0, 5'b00000, 5'b00000, 3'd0, 1'b1, 1'b1, 1'b0, 5'b10010};
    vecs[2]  = '{1'b0, 5'b00000, 5'b00000, 3'd5, 1'b0, 1'b1, 1'b0, 5'b10010};
    vecs[3]  = '{1'b0, 5'b00000, 5'b00000, 3'd5, 1'b1, 1'b0, 1'b0, 5'b10010};
    vecs[4]  = '{1'b0, 5'b00000, 5'b00000, 3'd6, 1'b0, 1'b0, 1'b1, 5'b10010};
    vecs[5]  = '{1'b0, 5'b00000, 5'b00000, 3'd7, 1'b1, 1'b0, 1'b1, 5'b10010};
    vecs[6]  = '{1'b0, 5'b00000, 5'b00000, 3'd4, 1'b0, 1'b1, 1'b0, 5'b10010};
    vecs[7]  = '{1'b0, 5'b00000, 5'b00000, 3'd3, 1'b1, 1'b1, 1'b0, 5'b10010};
    vecs[8]  = '{1'b0, 5'b00000, 5'b00000, 3'd2, 1'b0, 1'b0, 1'b0, 5'b10010};
    vecs[9]  = '{1'b1, 5'b11111, 5'b00000, 3'd1, 1'b0, 1'b0, 1'b0, 5'b00000};
    vecs[10] = '{1'b1, 5'b00100, 5'b11111, 3'd2, 1'b0, 1'b1, 1'b0, 5'b00100};
    vecs[11] = '{1'b1, 5'b00000, 5'b11111, 3'd2, 1'b1, 1'b0, 1'b0, 5'b00100};
    vecs[12] = '{1'b0, 5'b11111, 5'b11111, 3'd0, 1'b0, 1'b0, 1'b0, 5'b00100};

    idle();
    s_ready = 1'b0;
    rst     = 1'b1;
    #1;
    chk("reset r_flag",     32'(r_flag),     32'h05);
    chk("reset s_valid",    32'(s_valid),    32'h0);
    chk("reset s_flag",     32'(s_flag),     32'h0);
    chk("reset sel_err",    32'(sel_err),    32'h0);
    chk("reset cond_ready", 32'(cond_ready), 32'h1);
    tick();
    rst = 1'b0;
    tick();

    // Select/invert sweep and forwarding, back-to-back with S_READY high
    s_ready = 1'b1;
    for (int i = 0; i < 13; i++) begin
      flag_we = vecs[i].we; flag_mask = vecs[i].mask; flag_in = vecs[i].fin;
      sel_f = vecs[i].sel; inv_f = vecs[i].inv; cond_valid = 1'b1;
      #1;
      chk($sformatf("vec%0d cond_ready", i), 32'(cond_ready), 32'h1);
      tick();
      chk($sformatf("vec%0d s_valid", i), 32'(s_valid), 32'h1);
      chk($sformatf("vec%0d s_flag", i),  32'(s_flag),  32'(vecs[i].exp_flag));
      chk($sformatf("vec%0d sel_err", i), 32'(sel_err), 32'(vecs[i].exp_err));
      chk($sformatf("vec%0d r_flag", i),  32'(r_flag),  32'(vecs[i].exp_rflag));
    end
    idle();
    tick();
    chk("drain s_valid", 32'(s_valid), 32'h0);

    // Back-pressure: hold result while consumer stalls, flags keep updating
    s_ready = 1'b0;
    cond_valid = 1'b1; sel_f = 3'd5; inv_f = 1'b0;
    tick();
    chk("bp first valid", 32'(s_valid), 32'h1);
    chk("bp first flag",  32'(s_flag),  32'h1);
    sel_f = 3'd5; inv_f = 1'b1;
    for (int c = 0; c < 3; c++) begin
      flag_we = (c == 1); flag_mask = 5'b11111; flag_in = 5'b11000;
      #1;
      chk($sformatf("bp%0d cond_ready", c), 32'(cond_ready), 32'h0);
      tick();
      chk($sformatf("bp%0d s_valid", c), 32'(s_valid), 32'h1);
      chk($sformatf("bp%0d s_flag", c),  32'(s_flag),  32'h1);
    end
    flag_we = 1'b0;
    chk("bp flags updated", 32'(r_flag), 32'h18);
    s_ready = 1'b1;
    #1;
    chk("bp release cond_ready", 32'(cond_ready), 32'h1);
    tick();
    chk("bp reload s_valid", 32'(s_valid), 32'h1);
    chk("bp reload s_flag",  32'(s_flag),  32'h0);
    cond_valid = 1'b0;
    tick();
    chk("bp retire s_valid", 32'(s_valid), 32'h0);

    // Throughput: eight requests on eight cycles, results in order
    write_flags(5'b01101);
    tp_exp_flag = 8'b0010_1101;
    tp_exp_err  = 8'b1100_0000;
    for (int i = 0; i < 8; i++) begin
      cond_valid = 1'b1; sel_f = 3'(i); inv_f = 1'b0;
      tick();
      chk($sformatf("tp%0d s_valid", i), 32'(s_valid), 32'h1);
      chk($sformatf("tp%0d s_flag", i),  32'(s_flag),  32'(tp_exp_flag[i]));
      chk($sformatf("tp%0d sel_err", i), 32'(sel_err), 32'(tp_exp_err[i]));
    end
    idle();
    tick();

    // Async reset with a result pending and a request in flight
    s_ready = 1'b0;
    cond_valid = 1'b1; sel_f = 3'd2; inv_f = 1'b0;
    tick();
    chk("pre-reset s_flag", 32'(s_flag), 32'h1);
    rst = 1'b1;
    #1;
    chk("async reset r_flag",  32'(r_flag),  32'h05);
    chk("async reset s_valid", 32'(s_valid), 32'h0);
    chk("async reset s_flag",  32'(s_flag),  32'h0);
    #1;
    rst = 1'b0;
    idle();
    s_ready = 1'b1;
    tick();
    chk("post-reset s_valid", 32'(s_valid), 32'h0);

    // Shadow save / restore with forwarding
    write_flags(5'b01011);
    save = 1'b1;
    tick();
    save = 1'b0;
    write_flags(5'b00000);
    restore = 1'b1; cond_valid = 1'b1; sel_f = 3'd0; inv_f = 1'b0;
    tick();
    idle();
`ifdef FLAG_COND_SHADOW_EN
    chk("shadow r_flag", 32'(r_flag), 32'h0B);
    chk("shadow s_flag", 32'(s_flag), 32'h1);
`else
    chk("shadow r_flag", 32'(r_flag), 32'h00);
    chk("shadow s_flag", 32'(s_flag), 32'h0);
`endif
    chk("shadow s_valid", 32'(s_valid), 32'h1);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
